// File: rtl/hazard_ctrl_pipe_if.sv
// hazard_ctrl_pipe_if: decode-stage control bus, pipeline-register controls
// and hazard outputs of hazard_ctrl_pipe. The slave modport is the hazard block;
// the master modport is the control unit / datapath side.
interface hazard_ctrl_pipe_if #(
   parameter int CNT_W = 16
);
   // decode-stage controls and E-stage ALU flags
   logic             RegWriteD;
   logic [1:0]       ResultSrcD;
   logic             MemWriteD;
   logic             JumpD;
   logic             BranchD;
   logic             ALUSrcD;
   logic [2:0]       Funct3D;
   logic [4:0]       Rs1D;
   logic [4:0]       Rs2D;
   logic [4:0]       RdD;
   logic             ZeroE;
   logic             LtE;
   // registered controls and hazard results
   logic             ALUSrcE;
   logic             MemWriteM;
   logic             RegWriteM;
   logic             RegWriteW;
   logic [1:0]       ResultSrcW;
   logic [4:0]       RdM;
   logic [4:0]       RdW;
   logic             PCSrcE;
   logic [1:0]       ForwardAE;
   logic [1:0]       ForwardBE;
   logic             StallF;
   logic             StallD;
   logic             FlushD;
   logic             FlushE;
   logic [CNT_W-1:0] StallCnt;
   logic [CNT_W-1:0] FlushCnt;

   modport master (
      output RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD,
             Funct3D, Rs1D, Rs2D, RdD, ZeroE, LtE,
      input  ALUSrcE, MemWriteM, RegWriteM, RegWriteW, ResultSrcW, RdM, RdW,
             PCSrcE, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
             StallCnt, FlushCnt
   );

   modport slave (
      input  RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD,
             Funct3D, Rs1D, Rs2D, RdD, ZeroE, LtE,
      output ALUSrcE, MemWriteM, RegWriteM, RegWriteW, ResultSrcW, RdM, RdW,
             PCSrcE, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
             StallCnt, FlushCnt
   );
endinterface

// File: rtl/hazard_ctrl_pipe.sv
// hazard_ctrl_pipe: carries decode controls through the E/M/W pipeline
// registers of the 5-stage RV32I core, resolves branches in E and produces
// stall, flush and forwarding selects.
// Optional stall/flush performance counters are built when HAZARD_PERF_CNT_EN
// is defined; otherwise StallCnt/FlushCnt are tied to zero.
module hazard_ctrl_pipe #(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   hazard_ctrl_pipe_if.slave bus
);
   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic       alu_src;
      logic [2:0] funct3;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } ctl_t;

   ctl_t       ctl_d;
   ctl_t       ctl_e;
   logic       reg_write_m;
   logic       mem_write_m;
   logic [1:0] result_src_m;
   logic [4:0] rd_m;
   logic       reg_write_w;
   logic [1:0] result_src_w;
   logic [4:0] rd_w;
   logic       br_cond;
   logic       taken;
   logic       pc_src;
   logic       lw_stall;
   logic       stall;
   logic       flush_e;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   // gather the decode-stage control word
   always_comb begin
      ctl_d.reg_write  = bus.RegWriteD;
      ctl_d.result_src = bus.ResultSrcD;
      ctl_d.mem_write  = bus.MemWriteD;
      ctl_d.jump       = bus.JumpD;
      ctl_d.branch     = bus.BranchD;
      ctl_d.alu_src    = bus.ALUSrcD;
      ctl_d.funct3     = bus.Funct3D;
      ctl_d.rs1        = bus.Rs1D;
      ctl_d.rs2        = bus.Rs2D;
      ctl_d.rd         = bus.RdD;
   end

   // E stage: load decode controls, or an all-zero bubble on reset/flush
   always_ff @(posedge clk) begin
      if (!rst_n || flush_e) ctl_e <= '0;
      else                   ctl_e <= ctl_d;
   end

   // M and W stages always advance; reset discards everything in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reg_write_m  <= 1'b0;
         mem_write_m  <= 1'b0;
         result_src_m <= 2'b00;
         rd_m         <= 5'd0;
         reg_write_w  <= 1'b0;
         result_src_w <= 2'b00;
         rd_w         <= 5'd0;
      end else begin
         reg_write_m  <= ctl_e.reg_write;
         mem_write_m  <= ctl_e.mem_write;
         result_src_m <= ctl_e.result_src;
         rd_m         <= ctl_e.rd;
         reg_write_w  <= reg_write_m;
         result_src_w <= result_src_m;
         rd_w         <= rd_m;
      end
   end

   // branch resolution in E; unsupported funct3 codes never take
   always_comb begin
      br_cond = 1'b0;
      case (ctl_e.funct3)
         3'b000:  br_cond = bus.ZeroE;
         3'b001:  br_cond = ~bus.ZeroE;
         3'b100:  br_cond = bus.LtE;
         3'b101:  br_cond = ~bus.LtE;
         default: br_cond = 1'b0;
      endcase
      taken  = ctl_e.branch & br_cond;
      pc_src = taken | ctl_e.jump;
   end

   // load-use detection; a redirect squashes D, so it wins over the stall
   always_comb begin
      lw_stall = (ctl_e.result_src == 2'b01) && (ctl_e.rd != 5'd0) &&
                 ((ctl_e.rd == bus.Rs1D) || (ctl_e.rd == bus.Rs2D));
      stall    = lw_stall & ~pc_src;
      flush_e  = lw_stall | pc_src;
   end

   // operand forwarding for E: youngest producer (M) beats W, x0 never forwarded
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (reg_write_m && rd_m != 5'd0 && rd_m == ctl_e.rs1)      fwd_a = 2'b10;
      else if (reg_write_w && rd_w != 5'd0 && rd_w == ctl_e.rs1) fwd_a = 2'b01;
      if (reg_write_m && rd_m != 5'd0 && rd_m == ctl_e.rs2)      fwd_b = 2'b10;
      else if (reg_write_w && rd_w != 5'd0 && rd_w == ctl_e.rs2) fwd_b = 2'b01;
   end

   assign bus.ALUSrcE    = ctl_e.alu_src;
   assign bus.MemWriteM  = mem_write_m;
   assign bus.RegWriteM  = reg_write_m;
   assign bus.RegWriteW  = reg_write_w;
   assign bus.ResultSrcW = result_src_w;
   assign bus.RdM        = rd_m;
   assign bus.RdW        = rd_w;
   assign bus.PCSrcE     = pc_src;
   assign bus.ForwardAE  = fwd_a;
   assign bus.ForwardBE  = fwd_b;
   assign bus.StallF     = stall;
   assign bus.StallD     = stall;
   assign bus.FlushD     = pc_src;
   assign bus.FlushE     = flush_e;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // saturating event counters, cleared by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && stall_cnt != {CNT_W{1'b1}})   stall_cnt <= stall_cnt + 1'b1;
         if (flush_e && flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign bus.StallCnt = stall_cnt;
   assign bus.FlushCnt = flush_cnt;
`else
   assign bus.StallCnt = {CNT_W{1'b0}};
   assign bus.FlushCnt = {CNT_W{1'b0}};
`endif
endmodule
